aes_inv_128: RTL and testbench

AES_INV_128 -- requirements
Module: aes_inv_128

---
 rtl/aes_pkg.sv | 70 +++++++
 rtl/aes_inv_sbox.sv | 15 +
 rtl/aes_sbox.sv | 15 +
 rtl/aes_inv_128.sv | 134 +++++++++++++
 tb/tb_aes_inv_128.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 types, Rcon table and GF(2^8) helpers
package aes_pkg;

    typedef enum logic [1:0] {IDLE, KEYX, DEC, DONE} aes_state_e;
    typedef logic [3:0] round_cnt_t;

    localparam round_cnt_t LAST_KEY_STEP   = 4'd10;
    localparam round_cnt_t FIRST_DEC_ROUND = 4'd9;

    function automatic logic [7:0] rcon(input round_cnt_t idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // x^254 == x^-1 in GF(2^8); maps 0 to 0 as the S-box needs
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input logic [2:0] n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gf_mul(a0, 8'd14) ^ gf_mul(a1, 8'd11) ^ gf_mul(a2, 8'd13) ^ gf_mul(a3, 8'd9),
                gf_mul(a0, 8'd9)  ^ gf_mul(a1, 8'd14) ^ gf_mul(a2, 8'd11) ^ gf_mul(a3, 8'd13),
                gf_mul(a0, 8'd13) ^ gf_mul(a1, 8'd9)  ^ gf_mul(a2, 8'd14) ^ gf_mul(a3, 8'd11),
                gf_mul(a0, 8'd11) ^ gf_mul(a1, 8'd13) ^ gf_mul(a2, 8'd9)  ^ gf_mul(a3, 8'd14)};
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// rtl/aes_inv_sbox.sv - inverse AES S-box, combinational
module aes_inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    logic [7:0] pre;

    // undo the affine map first, then take the field inverse
    assign pre      = rotl8(in_byte, 3'd1) ^ rotl8(in_byte, 3'd3) ^ rotl8(in_byte, 3'd6) ^ 8'h05;
    assign out_byte = gf_inv(pre);

endmodule

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - forward AES S-box, combinational
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    logic [7:0] inv;

    assign inv      = gf_inv(in_byte);
    assign out_byte = inv ^ rotl8(inv, 3'd1) ^ rotl8(inv, 3'd2) ^ rotl8(inv, 3'd3)
                    ^ rotl8(inv, 3'd4) ^ 8'h63;

endmodule

// File: rtl/aes_inv_128.sv
// rtl/aes_inv_128.sv - iterative AES-128 decryptor, one round per cycle
module aes_inv_128 (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ct,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] pt
);
    import aes_pkg::*;

    aes_state_e   state_q, state_d;
    round_cnt_t   cnt_q, cnt_d;
    logic [127:0] key_q, key_d, data_q, data_d, pt_q, pt_d;

    logic [31:0]  w0, w1, w2, w3, u1, u2, u3;
    logic [31:0]  sb_word, sb_in, sb_out, sched_t;
    logic [7:0]   rc;
    logic [127:0] rk_fwd, rk_inv;
    logic [127:0] isr, isb, ark, round_out;

    // one S-box bank serves both directions: w3 going forward, recovered w3 going back
    always_comb begin : key_pre
        {w0, w1, w2, w3} = key_q;
        u3      = w3 ^ w2;
        u2      = w2 ^ w1;
        u1      = w1 ^ w0;
        sb_word = (state_q == KEYX) ? w3 : u3;
        sb_in   = {sb_word[23:0], sb_word[31:24]};
        rc      = rcon((state_q == KEYX) ? cnt_q : cnt_q + 4'd1);
    end

    for (genvar g = 0; g < 4; g++) begin : g_key_sbox
        aes_sbox u_sbox (.in_byte(sb_in[8*g +: 8]), .out_byte(sb_out[8*g +: 8]));
    end

    always_comb begin : key_post
        logic [31:0] f0, f1, f2;
        sched_t = sb_out ^ {rc, 24'h000000};
        f0      = w0 ^ sched_t;
        f1      = f0 ^ w1;
        f2      = f1 ^ w2;
        rk_fwd  = {f0, f1, f2, f2 ^ w3};
        rk_inv  = {w0 ^ sched_t, u1, u2, u3};
    end

    always_comb begin : round_pre
        isr = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                isr[127 - 8*(r + 4*c) -: 8] = data_q[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8];
            end
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_inv_sbox
        aes_inv_sbox u_inv_sbox (.in_byte(isr[8*g +: 8]), .out_byte(isb[8*g +: 8]));
    end

    always_comb begin : round_post
        ark       = isb ^ rk_inv;
        round_out = ark;
        if (cnt_q != 4'd0) begin
            for (int c = 0; c < 4; c++) begin
                round_out[127 - 32*c -: 32] = inv_mix_col(ark[127 - 32*c -: 32]);
            end
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        data_d  = data_q;
        pt_d    = pt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = KEYX;
                    cnt_d   = 4'd1;
                    key_d   = key;
                    data_d  = ct;
                end
            end
            KEYX: begin
                key_d = rk_fwd;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_KEY_STEP) begin
                    data_d  = data_q ^ rk_fwd;
                    cnt_d   = FIRST_DEC_ROUND;
                    state_d = DEC;
                end
            end
            DEC: begin
                key_d  = rk_inv;
                data_d = round_out;
                cnt_d  = cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    pt_d    = round_out;
                    cnt_d   = 4'd0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            key_q   <= '0;
            data_q  <= '0;
            pt_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            data_q  <= data_d;
            pt_q    <= pt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign pt        = pt_q;

endmodule

// File: tb/tb_aes_inv_128.sv
// tb/tb_aes_inv_128.sv - randomized self-checking bench for aes_inv_128
module tb_aes_inv_128;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] ct;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] pt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sbox_tab [256];

    always #5 clk = ~clk;

    aes_inv_128 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ct        (ct),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pt        (pt)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mxt(input logic [7:0] x);
        logic [7:0] y;
        y = {x[6:0], 1'b0};
        if (x[7]) y = y ^ 8'h1b;
        return y;
    endfunction

    // S-box built by walking the multiplicative group with generator 3
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        for (int i = 0; i < 255; i++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_tab[p] = x ^ 8'h63;
        end
        sbox_tab[0] = 8'h63;
    endtask

    // forward cipher: random plaintext is encrypted here and the DUT must recover it
    function automatic logic [127:0] model_encrypt(input logic [127:0] p, input logic [127:0] k);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rcv, a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        rcv = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]],
                       sbox_tab[tmp[31:24]]} ^ {rcv, 24'h000000};
                rcv = mxt(rcv);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = p[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_tab[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[r + 4*c] = t[r + 4*((c + r) % 4)];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = mxt(a0) ^ mxt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ mxt(a1) ^ mxt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ mxt(a2) ^ mxt(a3) ^ a3;
                    s[4*c+3] = mxt(a0) ^ a0 ^ a1 ^ a2 ^ mxt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31 - 8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // entered and left at posedge+1 with the DUT idle
    task automatic run_job(input logic [127:0] c, input logic [127:0] k, input logic [127:0] e,
                           input bit toggle, input int bp, input string name);
        int lat;
        in_valid  = 1'b1;
        ct        = c;
        key       = k;
        out_ready = 1'b0;
        @(posedge clk); #1;
        check({name, "_accept"}, 128'(in_ready), 128'd0);
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 40) begin
            if (toggle) begin
                in_valid = 1'($urandom_range(1));
                ct       = rand128();
                key      = rand128();
            end
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        check({name, "_latency"}, 128'(lat), 128'd20);
        check({name, "_pt"}, pt, e);
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            check({name, "_bp_valid"}, 128'(out_valid), 128'd1);
            check({name, "_bp_pt"}, pt, e);
            check({name, "_bp_ready"}, 128'(in_ready), 128'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, "_drain_valid"}, 128'(out_valid), 128'd0);
        check({name, "_drain_ready"}, 128'(in_ready), 128'd1);
    endtask

    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] rp, rk, rct;
        logic [127:0] cv_ct [3];
        logic [127:0] cv_key [3];
        logic [127:0] cv_pt [3];
        int acc_cyc [3];
        int acc_n, out_n, cyc;
        logic rdy_pre, vin_pre, ov_pre;
        logic [127:0] pt_pre;

        build_sbox();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ct        = '0;
        key       = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_pt", pt, 128'd0);

        run_job(B_CT, B_KEY, B_PT, 1'b0, 0, "fips_b");
        run_job(C1_CT, C1_KEY, C1_PT, 1'b1, 2, "fips_c1");
        run_job(Z_CT, 128'd0, 128'd0, 1'b1, 5, "zero_key");

        for (int i = 0; i < 6; i++) begin
            rp  = rand128();
            rk  = rand128();
            rct = model_encrypt(rp, rk);
            run_job(rct, rk, rp, 1'(i % 2), i % 3, "rand");
        end

        // abort mid-job with an asynchronous reset
        in_valid = 1'b1;
        ct       = B_CT;
        key      = B_KEY;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 128'(out_valid), 128'd0);
        check("abort_in_ready", 128'(in_ready), 128'd1);
        check("abort_pt", pt, 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_release_ready", 128'(in_ready), 128'd1);
        check("abort_release_valid", 128'(out_valid), 128'd0);
        run_job(B_CT, B_KEY, B_PT, 1'b0, 0, "after_abort");

        // streaming: in_valid held high, out_ready tied high
        cv_ct[0] = B_CT;  cv_key[0] = B_KEY;  cv_pt[0] = B_PT;
        cv_ct[1] = C1_CT; cv_key[1] = C1_KEY; cv_pt[1] = C1_PT;
        cv_ct[2] = Z_CT;  cv_key[2] = 128'd0; cv_pt[2] = 128'd0;
        acc_n     = 0;
        out_n     = 0;
        cyc       = 0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        ct        = cv_ct[0];
        key       = cv_key[0];
        while (out_n < 3 && cyc < 200) begin
            rdy_pre = in_ready;
            vin_pre = in_valid;
            ov_pre  = out_valid;
            pt_pre  = pt;
            @(posedge clk); #1;
            cyc++;
            if (rdy_pre && vin_pre) begin
                acc_cyc[acc_n] = cyc;
                acc_n++;
                if (acc_n < 3) begin
                    ct  = cv_ct[acc_n];
                    key = cv_key[acc_n];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (ov_pre) begin
                check("stream_pt", pt_pre, cv_pt[out_n]);
                out_n++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("stream_outputs", 128'(out_n), 128'd3);
        check("stream_accepts", 128'(acc_n), 128'd3);
        if (acc_n == 3) begin
            check("stream_gap_1", 128'(acc_cyc[1] - acc_cyc[0]), 128'd22);
            check("stream_gap_2", 128'(acc_cyc[2] - acc_cyc[1]), 128'd22);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
